// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor slice per clock.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic d_bit;
    logic bn;

    // Single full-subtractor slice acting on the shift-register LSBs.
    always_comb begin
        d_bit = a_q[0] ^ b_q[0] ^ br_q;
        bn    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
`ifdef SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    diff_d  = '0;
`ifdef SUB_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so diff ends LSB-aligned after WIDTH shifts.
                diff_d = (diff_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = bn;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bout_d  = bn;
                    done_d  = 1'b1;
`ifdef SUB_OVF_EN
                    ovf_d   = br_q ^ bn;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
